// File: rtl/acp_audio_pkg.sv
// Shared audio constants, mute state encoding and ramp helper
// for the PWM audio output path.
package acp_audio_pkg;

    localparam logic [7:0] AUDIO_MIDSCALE = 8'd128;
    localparam logic [6:0] RAMP_MAX_STEPS = 7'd127;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        RAMP_DOWN = 2'd1,
        MUTED     = 2'd2,
        RAMP_UP   = 2'd3
    } mute_state_e;

    // One unit step of cur toward tgt; holds when already equal.
    function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                               input logic [7:0] tgt);
        if (cur < tgt) begin
            return cur + 8'd1;
        end else if (cur > tgt) begin
            return cur - 8'd1;
        end
        return cur;
    endfunction

endpackage

// File: rtl/mute_ramp.sv
// Mute state machine and duty level register, advanced only at load points.
// PWM_AUDIO_SOFTMUTE_EN selects the ramped four-state mute.
module mute_ramp
    import acp_audio_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       mute,
    input  logic [7:0] audio_in,
    output logic [7:0] level,
    output logic [7:0] level_nxt,
    output logic       muted
);

    mute_state_e state_q, state_d;
    logic [7:0]  level_q, level_d;

`ifdef PWM_AUDIO_SOFTMUTE_EN
    logic [6:0]  step_cnt_q, step_cnt_d;

    // Next state, next level and catch-up step count at each load point
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        step_cnt_d = step_cnt_q;
        if (load) begin
            unique case (state_q)
                PLAY: begin
                    level_d = audio_in;
                    if (mute) state_d = RAMP_DOWN;
                end
                RAMP_DOWN: begin
                    level_d = step_toward(level_q, AUDIO_MIDSCALE);
                    if (!mute) begin
                        state_d    = RAMP_UP;
                        step_cnt_d = '0;
                    end else if (level_d == AUDIO_MIDSCALE) begin
                        state_d = MUTED;
                    end
                end
                MUTED: begin
                    level_d = AUDIO_MIDSCALE;
                    if (!mute) begin
                        state_d    = RAMP_UP;
                        step_cnt_d = '0;
                    end
                end
                RAMP_UP: begin
                    level_d    = step_toward(level_q, audio_in);
                    step_cnt_d = step_cnt_q + 7'd1;
                    if (mute) begin
                        state_d = RAMP_DOWN;
                    end else if (level_d == audio_in ||
                                 step_cnt_q == RAMP_MAX_STEPS) begin
                        state_d = PLAY;
                    end
                end
                default: state_d = MUTED;
            endcase
        end
    end

    // State, level and step counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= MUTED;
            level_q    <= AUDIO_MIDSCALE;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            step_cnt_q <= step_cnt_d;
        end
    end
`else
    // Hard mute: park at midscale or pass the sample at each load point
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (load) begin
            if (mute) begin
                state_d = MUTED;
                level_d = AUDIO_MIDSCALE;
            end else begin
                state_d = PLAY;
                level_d = audio_in;
            end
        end
    end

    // State and level registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MUTED;
            level_q <= AUDIO_MIDSCALE;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
        end
    end
`endif

    assign level     = level_q;
    assign level_nxt = level_d;
    assign muted     = (state_q == MUTED);

endmodule

// File: rtl/pwm_audio_out.sv
// 8-bit sample to 1-bit PWM with prescaler, period strobe and mute.
// Define PWM_AUDIO_SOFTMUTE_EN for the ramped soft mute.
module pwm_audio_out
    import acp_audio_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] audio_in,
    input  logic       mute,
    output logic       pwm_out,
    output logic       period_strobe,
    output logic [7:0] level,
    output logic       muted
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic        pwm_out_q, pwm_out_d;
    logic        strobe_q, strobe_d;
    logic        tick, load;
    logic [7:0]  level_nxt;

    assign tick = (pre_cnt_q == PRE_LAST);
    assign load = tick && (pwm_cnt_q == 8'hFF);

    mute_ramp u_mute_ramp (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .mute      (mute),
        .audio_in  (audio_in),
        .level     (level),
        .level_nxt (level_nxt),
        .muted     (muted)
    );

    // Counters advance; compare and strobe use the post-edge values
    // so the registered outputs line up with the counter they describe
    always_comb begin
        pre_cnt_d = tick ? 16'd0 : pre_cnt_q + 16'd1;
        pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        pwm_out_d = (pwm_cnt_d < level_nxt);
        strobe_d  = (pwm_cnt_d == 8'd0) && (pre_cnt_d == 16'd0);
    end

    // Counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
            pwm_out_q <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            pwm_out_q <= pwm_out_d;
            strobe_q  <= strobe_d;
        end
    end

    assign pwm_out       = pwm_out_q;
    assign period_strobe = strobe_q;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Directed bench for pwm_audio_out at PRESCALE=1.
// Soft-mute ramp checks run when PWM_AUDIO_SOFTMUTE_EN is defined.
module tb_pwm_audio_out;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] audio_in;
    logic       mute;
    logic       pwm_out;
    logic       period_strobe;
    logic [7:0] level;
    logic       muted;

    int total = 0;
    int bad   = 0;
    int hi;
    int st;
    int n;

    pwm_audio_out #(.PRESCALE(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .audio_in      (audio_in),
        .mute          (mute),
        .pwm_out       (pwm_out),
        .period_strobe (period_strobe),
        .level         (level),
        .muted         (muted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clocks, ending 1 time unit after a rising edge
    task automatic run_clks(input int cnt);
        repeat (cnt) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Count pwm_out highs and strobes over one 256-clock period
    task automatic measure(output int h, output int s);
        h = 0;
        s = 0;
        for (int i = 0; i < 256; i++) begin
            h += int'(pwm_out);
            s += int'(period_strobe);
            run_clks(1);
        end
    endtask

    // Release reset and count edges up to the first strobe
    task automatic release_and_wait(output int edges);
        @(negedge clk);
        rst = 1'b0;
        edges = 0;
        do begin
            run_clks(1);
            edges++;
        end while (!period_strobe && edges < 1000);
    endtask

    initial begin
        mute = 1'b0;
`ifdef PWM_AUDIO_SOFTMUTE_EN
        audio_in = 8'd128;
`else
        audio_in = 8'd64;
`endif
        #2 rst = 1'b1;
        #20;
        check("rst_pwm_out", pwm_out, 0);
        check("rst_strobe", period_strobe, 0);
        check("rst_level", level, 128);
        check("rst_muted", muted, 1);

        release_and_wait(n);
        check("first_strobe_edges", n, 256);
`ifdef PWM_AUDIO_SOFTMUTE_EN
        check("first_load_level", level, 128);
        check("first_load_muted", muted, 0);
        run_clks(256);
        audio_in = 8'd64;
        run_clks(256);
        check("play_level_64", level, 64);
`else
        check("first_load_level", level, 64);
        check("first_load_muted", muted, 0);
`endif

        measure(hi, st);
        check("duty_64", hi, 64);
        check("strobes_per_period", st, 1);
        check("strobe_next_period", period_strobe, 1);

        audio_in = 8'd0;
        run_clks(256);
        audio_in = 8'd255;
        measure(hi, st);
        check("duty_0", hi, 0);
        measure(hi, st);
        check("duty_255", hi, 255);

        audio_in = 8'd32;
        run_clks(256);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == 128) audio_in = 8'd200;
            hi += int'(pwm_out);
            run_clks(1);
        end
        check("load_keep_32", hi, 32);
        measure(hi, st);
        check("load_next_200", hi, 200);

`ifdef PWM_AUDIO_SOFTMUTE_EN
        audio_in = 8'd138;
        run_clks(256);
        check("ramp_start_level", level, 138);
        mute = 1'b1;
        run_clks(256);
        check("ramp_enter_level", level, 138);
        check("ramp_enter_muted", muted, 0);
        for (int k = 1; k <= 10; k++) begin
            run_clks(256);
            check($sformatf("ramp_down_%0d", k), level, 138 - k);
        end
        check("ramp_down_muted", muted, 1);
        mute = 1'b0;
        run_clks(256);
        check("unmute_level", level, 128);
        check("unmute_muted", muted, 0);
        for (int k = 1; k <= 10; k++) begin
            run_clks(256);
            check($sformatf("ramp_up_%0d", k), level, 128 + k);
        end
        audio_in = 8'd126;
        run_clks(256);
        check("ramp_up_play", level, 126);

        mute = 1'b1;
        run_clks(3 * 256);
        check("bound_pre_muted", muted, 1);
        audio_in = 8'd0;
        mute = 1'b0;
        run_clks(256);
        run_clks(127 * 256);
        check("bound_step127_level", level, 1);
        check("bound_step127_muted", muted, 0);
        run_clks(256);
        check("bound_end_level", level, 0);
        audio_in = 8'd127;
        run_clks(256);
        check("bound_play_level", level, 127);

        mute = 1'b1;
        run_clks(2 * 256);
        check("toggle_pre_muted", muted, 1);
        mute = 1'b0;
        run_clks(256);
        for (int k = 1; k <= 128; k++) begin
            audio_in = (k % 2 == 1) ? 8'd0 : 8'd255;
            run_clks(256);
            if (k == 127) check("toggle_step127", level, 127);
        end
        check("toggle_end_level", level, 128);
        audio_in = 8'd77;
        run_clks(256);
        check("toggle_forced_play", level, 77);

        mute = 1'b1;
        run_clks(2 * 256);
        check("rst_ramp_level", level, 78);
        run_clks(50);
`else
        mute = 1'b1;
        run_clks(256);
        check("mute_level", level, 128);
        check("mute_muted", muted, 1);
        measure(hi, st);
        check("mute_duty", hi, 128);
        mute = 1'b0;
        audio_in = 8'd100;
        run_clks(256);
        check("unmute_level", level, 100);
        check("unmute_muted", muted, 0);
        run_clks(50);
`endif
        check("pre_rst_pwm_out", pwm_out, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_pwm_out", pwm_out, 0);
        check("mid_rst_level", level, 128);
        check("mid_rst_muted", muted, 1);
        check("mid_rst_strobe", period_strobe, 0);
        release_and_wait(n);
        check("post_rst_strobe_edges", n, 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_audio_out.md
# pwm_audio_out

- Converts the 8-bit unsigned mixer output into a 1-bit PWM stream for the board's audio pin, with a registered output and no combinational path from the input.
- Sits downstream of `mixer_8bit_4ch`: `audio_in` connects directly to the mixer's `out`.
- Provides a period strobe so upstream sequencers can align note events to sample boundaries.
- Provides a mute that parks the output at midscale (128).

## Interface
- `PRESCALE`, default 1: clocks per PWM counter step (1..65535). The PWM period is 256×PRESCALE clocks, i.e. 195.3 kHz at 50 MHz.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `audio_in`  in  8  unsigned sample, midscale 128. Need not be registered upstream.
- `mute`  in  1  level-sensitive mute request.
- `pwm_out`  out  1  registered PWM output.
- `period_strobe`  out  1  one-cycle pulse on the first clock of each PWM period.
- `level`  out  8  duty value in force for the current period.
- `muted`  out  1  high while the output is parked at 128.

## Operation
- **Prescaler.** `pre_cnt` counts 0..PRESCALE-1. The tick fires when `pre_cnt` == PRESCALE-1. With PRESCALE=1 the tick is high every clock.
- **PWM counter.** 8-bit `pwm_cnt` advances on each tick and wraps 255→0.
- **Sample capture.** `audio_in` is sampled on the tick where `pwm_cnt` == 255. This is the load point, and `level` updates at that same edge.
- **Output.** During a period, `pwm_out` is high exactly while `pwm_cnt` < `level`.
  - `level` = 0 gives constant low.
  - `level` = 255 gives high for 255 of 256 steps; the output is never fully high.
- **Mute state machine** (states PLAY, RAMP_DOWN, MUTED, RAMP_UP; evaluated only at load points):
  - PLAY: `level` ← `audio_in`. If `mute`=1, go to RAMP_DOWN.
  - RAMP_DOWN: `level` steps ±1 toward 128. When `level` reaches 128, go to MUTED. If `mute`=0, go to RAMP_UP.
  - MUTED: `level` holds 128. If `mute`=0, go to RAMP_UP and clear `step_cnt`.
  - RAMP_UP: `level` steps ±1 toward the current `audio_in` and `step_cnt` increments.
    - Go to PLAY when `level` == `audio_in` or `step_cnt` == 127; the catch-up is bounded at 128 periods.
    - If `mute`=1, go to RAMP_DOWN.
- Entering PLAY loads `audio_in` at the next load point.
- `mute` changing between load points has no effect until the next load point.
- `muted` = (state == MUTED).

## Timing
- **Reset values:** `pre_cnt`=0, `pwm_cnt`=0, `level`=128, state=MUTED, `pwm_out`=0, `period_strobe`=0, `muted`=1, `step_cnt`=0.
- **After reset release:**
  - The first tick moves `pwm_cnt` 0→1.
  - With `mute`=0, state goes MUTED→RAMP_UP at the first load point.
- **`period_strobe`** is registered and high during the clock in which `pwm_cnt` == 0 with `pre_cnt` == 0. With PRESCALE=1 it pulses every 256 clocks.
- **`pwm_out`** is registered; it reflects `pwm_cnt`<`level` for the current counter value, with no extra lag beyond the registered compare.
- **Latency:** `audio_in` present at the load-point edge first affects `pwm_out` on the first clock of the next period.
- **Reset mid-period:** takes effect immediately (async); all registers return to their reset values and there is no partial period.

## Configuration
- Macro: `PWM_AUDIO_SOFTMUTE_EN`.
- **Defined:** the four-state ramped mute described above; worst-case ramp is 128 periods (≈0.66 ms at PRESCALE=1, 50 MHz).
- **Undefined:** only PLAY and MUTED exist.
  - `mute`=1 at a load point sets `level`=128 and enters MUTED immediately.
  - `mute`=0 at a load point loads `audio_in` and enters PLAY.
  - `step_cnt` is not built.
  - Reset state is still MUTED.

## Structure
- Package `acp_audio_pkg` holds:
  - constant `AUDIO_MIDSCALE` = 8'd128;
  - the mute state enum (PLAY, RAMP_DOWN, MUTED, RAMP_UP);
  - constant `RAMP_MAX_STEPS` = 127.
- One sub-module, `mute_ramp`, contains the state machine, `step_cnt` and `level` update. Its inputs are `load`, `mute` and `audio_in`; its outputs are `level` and `muted`.
- The top level contains the prescaler, PWM counter, compare and strobe.

## Test plan
- **Duty check.** Reset, `mute`=0, `audio_in`=64, PRESCALE=1, macro undefined → from the second period, `pwm_out` is high exactly 64 of every 256 clocks; `period_strobe` pulses every 256 clocks.
- **Endpoints.** `audio_in`=0 → `pwm_out` constant 0. `audio_in`=255 → `pwm_out` high 255/256 clocks.
- **Load timing.** Change `audio_in` 32→200 mid-period → the current period keeps 32, and the next period shows 200.
- **Soft-mute ramp (macro defined).** `audio_in`=138 in PLAY, assert `mute` → `level` reads 137, 136, …, 128 over 10 periods, then `muted`=1. Deassert `mute` → `level` ramps back to 138 over 10 periods and the state enters PLAY.
- **Ramp bound (macro defined).** Hold `audio_in`=0 then release `mute` from MUTED → RAMP_UP ends after 128 periods with `level`=0 (PLAY). Repeat with `audio_in` toggling 0/255 each period → PLAY is forced at step 127.
- **Reset mid-ramp.** Assert `rst` mid-period during RAMP_DOWN → outputs immediately go to `pwm_out`=0, `level`=128, `muted`=1; after release, the first `period_strobe` arrives 256×PRESCALE clocks later.
